// File: rtl/axi4_lite_slv_reg_file_pkg.sv
// Shared types and constants for the AXI4-Lite slave register file.
//   reg_mode_t : per-register access mode (RW, RO, W1C)
//   AXI4_RESP_* : response codes driven on bresp/rresp
//   wr_state_t / rd_state_t : write and read channel FSM states
package axi4_lite_reg_file_pkg;

  typedef enum logic [1:0] {
    REG_MODE_RW  = 2'd0,
    REG_MODE_RO  = 2'd1,
    REG_MODE_W1C = 2'd2
  } reg_mode_t;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_ACCEPT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_ACCEPT,
    RD_RESP
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_slv_reg_file_if.sv
// AXI4-Lite bus bundle.
//   slv_port : seen from the slave (address/data/ready-for-response in, readies/responses out)
//   mst_port : seen from the master (mirror of slv_port)
interface axi4_lite_if #(
  parameter int unsigned AXI4_LITE_ADDR_BIT_WIDTH = 5,
  parameter int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32
);
  logic                                    awvalid;
  logic                                    awready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]     awaddr;
  logic [2:0]                              awprot;
  logic                                    wvalid;
  logic                                    wready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]     wdata;
  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0]   wstrb;
  logic                                    bvalid;
  logic                                    bready;
  logic [1:0]                              bresp;
  logic                                    arvalid;
  logic                                    arready;
  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]     araddr;
  logic [2:0]                              arprot;
  logic                                    rvalid;
  logic                                    rready;
  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]     rdata;
  logic [1:0]                              rresp;

  modport slv_port (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport mst_port (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_slv_reg_file_reg_cell.sv
// One register slot of the register file.
//   i_clk, i_sync_rst : clock, synchronous active-high reset (loads RESET_VAL; RO loads 0)
//   i_wr_en           : commit strobe for this slot
//   i_wr_data/i_wr_strb : write data and byte-lane enables
//   i_w1c_set         : per-bit set requests (W1C only), applied every cycle
//   o_val             : current contents (always 0 for RO)
module axi4_lite_reg_cell
  import axi4_lite_reg_file_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter reg_mode_t         MODE      = REG_MODE_RW,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                i_clk,
  input  logic                i_sync_rst,
  input  logic                i_wr_en,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_strb,
  input  logic [DATA_W-1:0]   i_w1c_set,
  output logic [DATA_W-1:0]   o_val
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] RST_VAL = (MODE == REG_MODE_RO) ? '0 : RESET_VAL;

  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] val_d;
  logic [DATA_W-1:0] lane_mask;
  logic              unused_in;

  always_comb begin
    lane_mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      lane_mask[b*8 +: 8] = {8{i_wr_strb[b]}};
    end
  end

  always_comb begin
    val_d = val_q;
    case (MODE)
      REG_MODE_RW: begin
        if (i_wr_en) val_d = (val_q & ~lane_mask) | (i_wr_data & lane_mask);
      end
      REG_MODE_W1C: begin
        if (i_wr_en) val_d = val_q & ~(i_wr_data & lane_mask);
        // set is OR-ed after the clear so it wins a same-cycle collision
        val_d = val_d | i_w1c_set;
      end
      default: val_d = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) val_q <= RST_VAL;
    else            val_q <= val_d;
  end

  assign o_val     = val_q;
  assign unused_in = ^{i_wr_en, i_wr_data, i_wr_strb, i_w1c_set};

endmodule

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite slave register file with NUM_REGS word-aligned registers.
//   i_clk, i_sync_rst : clock, synchronous active-high reset
//   if_s_axi4_lite    : AXI4-Lite slave port (awprot/arprot ignored)
//   o_regs            : register contents (RO slots read 0)
//   i_ro_vals         : values returned for reads of RO slots
//   i_w1c_set         : per-bit set requests for W1C slots
//   o_wr_pulse        : one-cycle pulse per slot on successful write commit
//   o_rd_pulse        : one-cycle pulse per slot on accepted read
// AW and W are accepted independently and held until both are present;
// the commit then happens on that edge and a single B response follows.
module axi4_lite_slv_reg_file
  import axi4_lite_reg_file_pkg::*;
#(
  parameter int unsigned AXI4_LITE_ADDR_BIT_WIDTH = 5,
  parameter int unsigned AXI4_LITE_DATA_BIT_WIDTH = 32,
  parameter int unsigned NUM_REGS                 = 8,
  parameter reg_mode_t [NUM_REGS-1:0] REG_MODES   = '0,
  parameter logic [NUM_REGS-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0] RESET_VALS = '0
) (
  input  logic                                                i_clk,
  input  logic                                                i_sync_rst,
  axi4_lite_if.slv_port                                       if_s_axi4_lite,
  output logic [NUM_REGS-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_regs,
  input  logic [NUM_REGS-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_ro_vals,
  input  logic [NUM_REGS-1:0][AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_w1c_set,
  output logic [NUM_REGS-1:0]                                 o_wr_pulse,
  output logic [NUM_REGS-1:0]                                 o_rd_pulse
);
  localparam int unsigned ADDR_W = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int unsigned DATA_W = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFS_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_W - OFS_W;

  wr_state_t          wr_state;
  rd_state_t          rd_state;
  logic               aw_held;
  logic               w_held;
  logic [IDX_W-1:0]   awidx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  wstrb_q;

  logic               aw_hs;
  logic               w_hs;
  logic               ar_hs;
  logic               commit;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  wr_data;
  logic [STRB_W-1:0]  wr_strb;
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] rd_sel;
  logic               wr_ro;
  logic               wr_ok;
  logic [DATA_W-1:0]  rd_val;
  logic               unused_bits;

  always_comb begin
    aw_hs   = if_s_axi4_lite.awvalid && if_s_axi4_lite.awready;
    w_hs    = if_s_axi4_lite.wvalid  && if_s_axi4_lite.wready;
    ar_hs   = if_s_axi4_lite.arvalid && if_s_axi4_lite.arready;
    commit  = (wr_state == WR_ACCEPT) && (aw_held || aw_hs) && (w_held || w_hs);
    wr_idx  = aw_held ? awidx_q : if_s_axi4_lite.awaddr[ADDR_W-1:OFS_W];
    wr_data = w_held  ? wdata_q : if_s_axi4_lite.wdata;
    wr_strb = w_held  ? wstrb_q : if_s_axi4_lite.wstrb;
    rd_idx  = if_s_axi4_lite.araddr[ADDR_W-1:OFS_W];
  end

  // An index that matches no slot is out of range; rd_val stays 0 for it.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    wr_ro  = 1'b0;
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        wr_sel[i] = 1'b1;
        wr_ro     = (REG_MODES[i] == REG_MODE_RO);
      end
      if (rd_idx == IDX_W'(i)) begin
        rd_sel[i] = 1'b1;
        rd_val    = (REG_MODES[i] == REG_MODE_RO) ? i_ro_vals[i] : o_regs[i];
      end
    end
    wr_ok = (|wr_sel) && !wr_ro;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    axi4_lite_reg_cell #(
      .DATA_W    (DATA_W),
      .MODE      (REG_MODES[g]),
      .RESET_VAL (RESET_VALS[g])
    ) u_cell (
      .i_clk      (i_clk),
      .i_sync_rst (i_sync_rst),
      .i_wr_en    (commit && wr_sel[g]),
      .i_wr_data  (wr_data),
      .i_wr_strb  (wr_strb),
      .i_w1c_set  (i_w1c_set[g]),
      .o_val      (o_regs[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      wr_state               <= WR_ACCEPT;
      aw_held                <= 1'b0;
      w_held                 <= 1'b0;
      awidx_q                <= '0;
      wdata_q                <= '0;
      wstrb_q                <= '0;
      if_s_axi4_lite.awready <= 1'b0;
      if_s_axi4_lite.wready  <= 1'b0;
      if_s_axi4_lite.bvalid  <= 1'b0;
      if_s_axi4_lite.bresp   <= AXI4_RESP_OKAY;
      o_wr_pulse             <= '0;
    end else begin
      o_wr_pulse <= '0;
      case (wr_state)
        WR_ACCEPT: begin
          if (commit) begin
            wr_state               <= WR_RESP;
            aw_held                <= 1'b0;
            w_held                 <= 1'b0;
            if_s_axi4_lite.awready <= 1'b0;
            if_s_axi4_lite.wready  <= 1'b0;
            if_s_axi4_lite.bvalid  <= 1'b1;
            if_s_axi4_lite.bresp   <= wr_ok ? AXI4_RESP_OKAY : AXI4_RESP_SLVERR;
            o_wr_pulse             <= wr_ok ? wr_sel : '0;
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              awidx_q <= if_s_axi4_lite.awaddr[ADDR_W-1:OFS_W];
            end
            if (w_hs) begin
              w_held  <= 1'b1;
              wdata_q <= if_s_axi4_lite.wdata;
              wstrb_q <= if_s_axi4_lite.wstrb;
            end
            if_s_axi4_lite.awready <= !(aw_held || aw_hs);
            if_s_axi4_lite.wready  <= !(w_held || w_hs);
          end
        end
        WR_RESP: begin
          if (if_s_axi4_lite.bvalid && if_s_axi4_lite.bready) begin
            wr_state               <= WR_ACCEPT;
            if_s_axi4_lite.bvalid  <= 1'b0;
            if_s_axi4_lite.awready <= 1'b1;
            if_s_axi4_lite.wready  <= 1'b1;
          end
        end
        default: wr_state <= WR_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      rd_state               <= RD_ACCEPT;
      if_s_axi4_lite.arready <= 1'b0;
      if_s_axi4_lite.rvalid  <= 1'b0;
      if_s_axi4_lite.rdata   <= '0;
      if_s_axi4_lite.rresp   <= AXI4_RESP_OKAY;
      o_rd_pulse             <= '0;
    end else begin
      o_rd_pulse <= '0;
      case (rd_state)
        RD_ACCEPT: begin
          if (ar_hs) begin
            rd_state               <= RD_RESP;
            if_s_axi4_lite.arready <= 1'b0;
            if_s_axi4_lite.rvalid  <= 1'b1;
            if_s_axi4_lite.rdata   <= rd_val;
            if_s_axi4_lite.rresp   <= (|rd_sel) ? AXI4_RESP_OKAY : AXI4_RESP_SLVERR;
            o_rd_pulse             <= rd_sel;
          end else begin
            if_s_axi4_lite.arready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (if_s_axi4_lite.rvalid && if_s_axi4_lite.rready) begin
            rd_state               <= RD_ACCEPT;
            if_s_axi4_lite.rvalid  <= 1'b0;
            if_s_axi4_lite.arready <= 1'b1;
          end
        end
        default: rd_state <= RD_ACCEPT;
      endcase
    end
  end

  assign unused_bits = ^{if_s_axi4_lite.awaddr[OFS_W-1:0], if_s_axi4_lite.araddr[OFS_W-1:0],
                         if_s_axi4_lite.awprot, if_s_axi4_lite.arprot};

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Testbench for axi4_lite_slv_reg_file: 8 registers, reg2 RO, reg3 W1C,
// reg0 resets to 0xDEADBEEF, 6-bit address so index 8 is out of range.
// Expected B/R responses are queued when a transaction is issued and
// compared by a monitor when the response first appears.
module tb_axi4_lite_slv_reg_file;
  import axi4_lite_reg_file_pkg::*;

  localparam reg_mode_t [7:0] MODES = {REG_MODE_RW, REG_MODE_RW, REG_MODE_RW, REG_MODE_RW,
                                       REG_MODE_W1C, REG_MODE_RO, REG_MODE_RW, REG_MODE_RW};
  localparam logic [7:0][31:0] RSTV = {224'h0, 32'hDEADBEEF};

  typedef struct packed {logic [1:0] resp; logic [7:0] pulse;} wexp_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic [7:0] pulse;} rexp_t;

  logic             i_clk = 1'b0;
  logic             rst;
  logic [7:0][31:0] regs;
  logic [7:0][31:0] ro_vals;
  logic [7:0][31:0] w1c_set;
  logic [7:0]       wr_pulse;
  logic [7:0]       rd_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  wexp_t wr_q[$];
  rexp_t rd_q[$];

  always #5 i_clk = ~i_clk;

  axi4_lite_if #(.AXI4_LITE_ADDR_BIT_WIDTH(6), .AXI4_LITE_DATA_BIT_WIDTH(32)) axi ();

  axi4_lite_slv_reg_file #(
    .AXI4_LITE_ADDR_BIT_WIDTH (6),
    .AXI4_LITE_DATA_BIT_WIDTH (32),
    .NUM_REGS                 (8),
    .REG_MODES                (MODES),
    .RESET_VALS               (RSTV)
  ) dut (
    .i_clk          (i_clk),
    .i_sync_rst     (rst),
    .if_s_axi4_lite (axi),
    .o_regs         (regs),
    .i_ro_vals      (ro_vals),
    .i_w1c_set      (w1c_set),
    .o_wr_pulse     (wr_pulse),
    .o_rd_pulse     (rd_pulse)
  );

  // Scoreboard monitor: compare each response on its first valid cycle.
  initial begin
    logic b_prev, r_prev;
    wexp_t we;
    rexp_t re;
    b_prev = 1'b0;
    r_prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (rst) begin
        b_prev = 1'b0;
        r_prev = 1'b0;
      end else begin
        if (axi.bvalid && !b_prev) begin
          n_checks++;
          if (wr_q.size() == 0) begin
            $display("FAIL b_unexpected: bresp=%b pulse=%b, required no response", axi.bresp, wr_pulse);
          end else begin
            we = wr_q.pop_front();
            if ({axi.bresp, wr_pulse} !== {we.resp, we.pulse})
              $display("FAIL b_resp: bresp=%b pulse=%b, required bresp=%b pulse=%b",
                       axi.bresp, wr_pulse, we.resp, we.pulse);
            else n_pass++;
          end
        end
        if (axi.rvalid && !r_prev) begin
          n_checks++;
          if (rd_q.size() == 0) begin
            $display("FAIL r_unexpected: rdata=%h rresp=%b, required no response", axi.rdata, axi.rresp);
          end else begin
            re = rd_q.pop_front();
            if ({axi.rdata, axi.rresp, rd_pulse} !== {re.data, re.resp, re.pulse})
              $display("FAIL r_resp: rdata=%h rresp=%b pulse=%b, required rdata=%h rresp=%b pulse=%b",
                       axi.rdata, axi.rresp, rd_pulse, re.data, re.resp, re.pulse);
            else n_pass++;
          end
        end
        b_prev = axi.bvalid;
        r_prev = axi.rvalid;
      end
    end
  end

  task automatic send_aw(input logic [5:0] a, input int dly);
    repeat (dly) @(negedge i_clk);
    axi.awvalid = 1'b1;
    axi.awaddr  = a;
    for (int n = 0; n < 50 && !axi.awready; n++) @(negedge i_clk);
    if (!axi.awready) begin
      n_checks++;
      $display("FAIL aw_timeout: awready=%b, required 1", axi.awready);
    end
    @(negedge i_clk);
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    repeat (dly) @(negedge i_clk);
    axi.wvalid = 1'b1;
    axi.wdata  = d;
    axi.wstrb  = s;
    for (int n = 0; n < 50 && !axi.wready; n++) @(negedge i_clk);
    if (!axi.wready) begin
      n_checks++;
      $display("FAIL w_timeout: wready=%b, required 1", axi.wready);
    end
    @(negedge i_clk);
    axi.wvalid = 1'b0;
  endtask

  task automatic wait_b();
    for (int n = 0; n < 50 && !(axi.bvalid && axi.bready); n++) @(negedge i_clk);
    if (!(axi.bvalid && axi.bready)) begin
      n_checks++;
      $display("FAIL b_timeout: bvalid=%b, required 1", axi.bvalid);
    end
    @(negedge i_clk);
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input logic [1:0] r, input logic [7:0] p);
    wr_q.push_back(wexp_t'{resp: r, pulse: p});
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    wait_b();
  endtask

  task automatic do_read(input logic [5:0] a, input logic [31:0] d, input logic [1:0] r,
                         input logic [7:0] p);
    rd_q.push_back(rexp_t'{data: d, resp: r, pulse: p});
    axi.arvalid = 1'b1;
    axi.araddr  = a;
    for (int n = 0; n < 50 && !axi.arready; n++) @(negedge i_clk);
    if (!axi.arready) begin
      n_checks++;
      $display("FAIL ar_timeout: arready=%b, required 1", axi.arready);
    end
    @(negedge i_clk);
    axi.arvalid = 1'b0;
    for (int n = 0; n < 50 && !(axi.rvalid && axi.rready); n++) @(negedge i_clk);
    if (!(axi.rvalid && axi.rready)) begin
      n_checks++;
      $display("FAIL r_timeout: rvalid=%b, required 1", axi.rvalid);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, wr_pulse, rd_pulse} !== '0)
      $display("FAIL reset_ctrl: aw/w/ar ready=%b%b%b b/rvalid=%b%b, required all 0",
               axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid);
    else n_pass++;
    n_checks++;
    if (regs !== RSTV) $display("FAIL reset_regs: o_regs=%h, required %h", regs, RSTV);
    else n_pass++;
    rst = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111)
      $display("FAIL ready_after_reset: ready=%b, required 111", {axi.awready, axi.wready, axi.arready});
    else n_pass++;
    do_read(6'h00, 32'hDEADBEEF, AXI4_RESP_OKAY, 8'h01);
  endtask

  task automatic test_write_order();
    do_write(6'h04, 32'h12345678, 4'hF, 0, 2, AXI4_RESP_OKAY, 8'h02);
    n_checks++;
    if (regs[1] !== 32'h12345678) $display("FAIL aw_first: reg1=%h, required 12345678", regs[1]);
    else n_pass++;
    do_write(6'h08, 32'hFFFFFFFF, 4'hF, 2, 0, AXI4_RESP_SLVERR, 8'h00);
    n_checks++;
    if (regs[2] !== 32'h0) $display("FAIL ro_write: reg2=%h, required 0", regs[2]);
    else n_pass++;
    do_read(6'h04, 32'h12345678, AXI4_RESP_OKAY, 8'h02);
  endtask

  task automatic test_byte_strobes();
    do_write(6'h00, 32'h87654321, 4'h5, 0, 0, AXI4_RESP_OKAY, 8'h01);
    n_checks++;
    if (regs[0] !== 32'hDE65BE21) $display("FAIL strobe_05: reg0=%h, required de65be21", regs[0]);
    else n_pass++;
    do_write(6'h04, 32'hFFFFFFFF, 4'h0, 0, 0, AXI4_RESP_OKAY, 8'h02);
    n_checks++;
    if (regs[1] !== 32'h12345678) $display("FAIL strobe_0: reg1=%h, required 12345678", regs[1]);
    else n_pass++;
  endtask

  task automatic test_w1c();
    w1c_set[3] = 32'h0000000F;
    @(negedge i_clk);
    w1c_set[3] = '0;
    n_checks++;
    if (regs[3] !== 32'h0000000F) $display("FAIL w1c_set: reg3=%h, required 0000000f", regs[3]);
    else n_pass++;
    do_write(6'h0C, 32'h00000005, 4'hF, 0, 0, AXI4_RESP_OKAY, 8'h08);
    n_checks++;
    if (regs[3] !== 32'h0000000A) $display("FAIL w1c_clear: reg3=%h, required 0000000a", regs[3]);
    else n_pass++;
    // clear bits 1:0 on the same edge that sets bit 0
    wr_q.push_back(wexp_t'{resp: AXI4_RESP_OKAY, pulse: 8'h08});
    axi.awvalid = 1'b1;
    axi.awaddr  = 6'h0C;
    axi.wvalid  = 1'b1;
    axi.wdata   = 32'h00000003;
    axi.wstrb   = 4'hF;
    w1c_set[3]  = 32'h00000001;
    @(negedge i_clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    w1c_set[3]  = '0;
    n_checks++;
    if (regs[3] !== 32'h00000009) $display("FAIL w1c_collide: reg3=%h, required 00000009", regs[3]);
    else n_pass++;
    wait_b();
  endtask

  task automatic test_out_of_range();
    do_read(6'h20, 32'h0, AXI4_RESP_SLVERR, 8'h00);
    do_write(6'h24, 32'hFFFFFFFF, 4'hF, 0, 0, AXI4_RESP_SLVERR, 8'h00);
    ro_vals[2] = 32'hCAFEF00D;
    do_read(6'h08, 32'hCAFEF00D, AXI4_RESP_OKAY, 8'h04);
    do_read(6'h0C, 32'h00000009, AXI4_RESP_OKAY, 8'h08);
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [8];
    logic [31:0] nv;
    for (int i = 4; i < 8; i++) begin
      model[i] = $urandom;
      do_write(6'(i * 4), model[i], 4'hF, 0, 0, AXI4_RESP_OKAY, 8'(1 << i));
    end
    for (int i = 4; i < 8; i++) do_read(6'(i * 4), model[i], AXI4_RESP_OKAY, 8'(1 << i));
    nv = ~model[5];
    // read accepted on the commit edge sees the old contents
    fork
      do_write(6'h14, nv, 4'hF, 0, 0, AXI4_RESP_OKAY, 8'h20);
      do_read(6'h14, model[5], AXI4_RESP_OKAY, 8'h20);
    join
    n_checks++;
    if (regs[5] !== nv) $display("FAIL collide_write: reg5=%h, required %h", regs[5], nv);
    else n_pass++;
  endtask

  task automatic test_backpressure_reset();
    axi.bready = 1'b0;
    wr_q.push_back(wexp_t'{resp: AXI4_RESP_OKAY, pulse: 8'h10});
    fork
      send_aw(6'h10, 0);
      send_w(32'h55AA55AA, 4'hF, 0);
    join
    n_checks++;
    if (regs[4] !== 32'h55AA55AA) $display("FAIL bp_write: reg4=%h, required 55aa55aa", regs[4]);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({axi.bvalid, axi.bresp} !== {1'b1, AXI4_RESP_OKAY})
        $display("FAIL bp_hold: bvalid=%b bresp=%b, required 1 00", axi.bvalid, axi.bresp);
      else n_pass++;
      @(negedge i_clk);
    end
    rst = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({axi.bvalid, wr_pulse, rd_pulse} !== '0)
      $display("FAIL rst_abort: bvalid=%b pulses=%b/%b, required 0", axi.bvalid, wr_pulse, rd_pulse);
    else n_pass++;
    n_checks++;
    if (regs !== RSTV) $display("FAIL rst_reload: o_regs=%h, required %h", regs, RSTV);
    else n_pass++;
    rst = 1'b0;
    axi.bready = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid} !== 4'b1110)
      $display("FAIL rst_recover: ready/bvalid=%b, required 1110",
               {axi.awready, axi.wready, axi.arready, axi.bvalid});
    else n_pass++;
    do_read(6'h00, 32'hDEADBEEF, AXI4_RESP_OKAY, 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    ro_vals     = '0;
    w1c_set     = '0;
    axi.awvalid = 1'b0;
    axi.awaddr  = '0;
    axi.awprot  = '0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.bready  = 1'b1;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.arprot  = '0;
    axi.rready  = 1'b1;
    test_reset();
    test_write_order();
    test_byte_strobes();
    test_w1c();
    test_out_of_range();
    test_back_to_back();
    test_backpressure_reset();
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0)
      $display("FAIL scoreboard_drain: pending wr=%0d rd=%0d, required 0 0", wr_q.size(), rd_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slv_reg_file.md
# axi4_lite_slv_reg_file

Parametrised AXI4-Lite slave register file, the successor to the fixed single-register slave template. It provides NUM_REGS 32-bit-aligned registers, each with a per-register access mode (RW, RO, W1C), byte-strobe writes, and AW/W channels accepted independently in either order. SLVERR is returned for out-of-range or illegal accesses. It sits between an AXI4-Lite interconnect port and the fabric's control/status logic.

## Interface
- AXI4_LITE_ADDR_BIT_WIDTH, 5, address width; must match the connected axi4_lite_if instance
- AXI4_LITE_DATA_BIT_WIDTH, 32, data width (32 or 64); must match the interface
- NUM_REGS, 8, register count, 1..2**(ADDR_W-log2(DATA_W/8))
- REG_MODES, all REG_MODE_RW, packed array [NUM_REGS] of reg_mode_t
- RESET_VALS, all 0, packed array [NUM_REGS] of DATA_W-bit reset values (RW/W1C only)
- i_clk  in  1  single clock, all logic on rising edge
- i_sync_rst  in  1  synchronous, active-high reset
- if_s_axi4_lite  modport slv_port  -  AXI4-Lite slave port (awprot/arprot ignored)
- o_regs  out  NUM_REGS*DATA_W  current register contents; RO slots drive 0
- i_ro_vals  in  NUM_REGS*DATA_W  values returned when reading RO registers
- i_w1c_set  in  NUM_REGS*DATA_W  per-bit set requests for W1C registers, sampled every cycle
- o_wr_pulse  out  NUM_REGS  1-cycle pulse on successful commit to index
- o_rd_pulse  out  NUM_REGS  1-cycle pulse on accepted read of index

## Operation
- Index = addr[ADDR_W-1 : log2(DATA_W/8)]; low byte-offset bits are ignored.
- Write FSM, states WR_ACCEPT and WR_RESP:
  - In WR_ACCEPT, awready=1 while no AW is latched and wready=1 while no W is latched. Each is latched on its own handshake.
  - Commit happens on the edge where both are available (latched or handshaking that edge). The FSM then goes to WR_RESP.
  - In WR_RESP, bvalid=1 and awready=wready=0. On bvalid&&bready the FSM returns to WR_ACCEPT.
- Write semantics per byte lane with wstrb=1:
  - RW: byte is replaced.
  - W1C: bits written with 1 clear.
  - RO, or index ≥ NUM_REGS: no change, bresp=SLVERR (2'b10). Otherwise bresp=OKAY (2'b00) and o_wr_pulse[idx] fires.
  - wstrb=0 with a valid index: OKAY, no change, pulse still fires.
- W1C set: i_w1c_set bits set the register every cycle. Set wins over a same-cycle clear.
- Read FSM, states RD_ACCEPT (arready=1) and RD_RESP (rvalid=1, arready=0):
  - On AR handshake, rdata/rresp are registered and o_rd_pulse[idx] fires.
  - RW/W1C return the register value; RO returns i_ro_vals at that edge.
  - Out of range returns rdata=0 with SLVERR.
  - On rvalid&&rready the FSM returns to RD_ACCEPT.
- Read and write FSMs are independent. A read accepted on the same edge as a write commit to the same index returns the pre-write value.

## Timing
- Reset values: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, o_regs=RESET_VALS, pulses=0. Latched AW/W state is cleared.
- awready/wready/arready are 1 from the first cycle after reset deassertion.
- Write latency: bvalid and updated o_regs are visible in the cycle after the commit edge.
- Read latency: rvalid is high in the cycle after the AR handshake.
- Throughput: one write per 2 cycles with bready held high; the same for reads.
- bvalid/rvalid, with their data and response, hold stable until accepted.
- Reset mid-transaction aborts both FSMs: pending response dropped, registers reloaded, no pulse emitted.

## Structure
- Package axi4_lite_reg_file_pkg contains:
  - reg_mode_t enum: REG_MODE_RW=2'd0, REG_MODE_RO=2'd1, REG_MODE_W1C=2'd2
  - AXI4_RESP_OKAY=2'b00, AXI4_RESP_SLVERR=2'b10
  - FSM state enums
- Sub-module axi4_lite_reg_cell, generated per index, implements mode, strobe merge, W1C set/clear and reset value. The top level holds the channel FSMs and address decode.

## Test plan
Configuration for all scenarios: NUM_REGS=8, reg2=RO, reg3=W1C, reg0 RESET_VAL=0xDEADBEEF.
- Reset: hold reset 2 cycles, then read 0x00 → rdata=0xDEADBEEF, OKAY; all ready signals 0 during reset.
- Write order: AW 0x04 two cycles before W 0x12345678 strobe 0xF, then W-first to 0x08 → bresp OKAY then SLVERR; read 0x04 → 0x12345678.
- Byte strobes: write 0x87654321 to 0x00 with wstrb=0x5 → o_regs[0]=0xDE65BE21.
- W1C: pulse i_w1c_set[3]=0x0000000F, then write 0x00000005 to 0x0C → reg3=0x0000000A. Repeat with a simultaneous set of bit0 → bit0 stays 1.
- Out of range: read 0x20-equivalent index 8 (ADDR_W=6 build) → rdata=0, SLVERR, no o_rd_pulse; i_ro_vals[2]=0xCAFEF00D → read 0x08 returns it.
- Backpressure and reset: hold bready=0 for 5 cycles → bvalid stays high with stable bresp. Assert reset while bvalid=1 → bvalid=0 next cycle and registers reloaded.
